// File: rtl/hl_ad9866_pkg.sv
// Shared definitions for the AD9866 serial-control sequencer.
// Contents:
//   - SPI frame layout: {R/W, byte count, addr[4:0], data[7:0]}, MSB first
//   - FSM state encoding
//   - Default codec init table as {addr, data} words (unused slots are zero)
//   - make_frame(): packs an address/data pair into a 16-bit write frame
package hl_ad9866_pkg;

    localparam int FRAME_W        = 16;
    localparam int FRAME_RW_POS   = 15;
    localparam int FRAME_LEN_POS  = 13;
    localparam int FRAME_LEN_W    = 2;
    localparam int FRAME_ADDR_POS = 8;
    localparam int FRAME_ADDR_W   = 5;
    localparam int FRAME_DATA_POS = 0;
    localparam int FRAME_DATA_W   = 8;
    localparam int ENTRY_W        = FRAME_ADDR_W + FRAME_DATA_W;
    localparam int INIT_MAX       = 32;

    typedef enum logic [1:0] {
        ST_RSTHOLD,
        ST_GAP,
        ST_FRAME,
        ST_IDLE
    } state_e;

    // Entry = {addr[4:0], data[7:0]}
    localparam logic [ENTRY_W-1:0] INIT_TABLE [INIT_MAX] = '{
        0:       13'h0120,
        1:       13'h0436,
        2:       13'h0540,
        3:       13'h064B,
        4:       13'h0700,
        5:       13'h0C41,
        6:       13'h0D00,
        7:       13'h1302,
        default: 13'h0000
    };

    function automatic logic [FRAME_W-1:0] make_frame(
        input logic [FRAME_ADDR_W-1:0] addr,
        input logic [FRAME_DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[FRAME_RW_POS]                        = 1'b0;   // write
        f[FRAME_LEN_POS +: FRAME_LEN_W]        = 2'b00;  // one byte
        f[FRAME_ADDR_POS +: FRAME_ADDR_W]      = addr;
        f[FRAME_DATA_POS +: FRAME_DATA_W]      = data;
        return f;
    endfunction

endpackage

// File: rtl/ad9866_spi_ctrl_if.sv
// Control-side bundle between the core and the AD9866 serial sequencer.
//   reinit    : one-cycle pulse, rerun init table
//   wr_req    : runtime write request, held until wr_ack
//   wr_addr   : register address (stable while wr_req)
//   wr_data   : register data (stable while wr_req)
//   wr_ack    : one-cycle pulse, request latched into shifter
//   busy      : sequencer not idle
//   init_done : init table complete
// master = core side, slave = sequencer side.
interface ad9866_spi_ctrl_if;
    import hl_ad9866_pkg::*;

    logic                    reinit;
    logic                    wr_req;
    logic [FRAME_ADDR_W-1:0] wr_addr;
    logic [FRAME_DATA_W-1:0] wr_data;
    logic                    wr_ack;
    logic                    busy;
    logic                    init_done;

    modport master (
        output reinit, wr_req, wr_addr, wr_data,
        input  wr_ack, busy, init_done
    );

    modport slave (
        input  reinit, wr_req, wr_addr, wr_data,
        output wr_ack, busy, init_done
    );
endinterface

// File: rtl/ad9866_init_rom.sv
// Combinational init-table lookup.
//   idx_i   : entry index 0..31
//   entry_o : {addr[4:0], data[7:0]}; zero for indices at or beyond NINIT
module ad9866_init_rom
    import hl_ad9866_pkg::*;
#(
    parameter int NINIT = 8
) (
    input  logic [4:0]         idx_i,
    output logic [ENTRY_W-1:0] entry_o
);

    always_comb begin
        entry_o = '0;
        if (int'(idx_i) < NINIT) begin
            entry_o = INIT_TABLE[idx_i];
        end
    end

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// AD9866 serial-control sequencer.
// After reset: holds ad9866_rst_n low for RSTCYC cycles, then writes NINIT
// init-table entries over 3-wire SPI, each followed by a 2*CLKDIV-cycle gap.
// Afterwards serves single-register writes from the core (req/ack).
// Ports:
//   ad9866spiclk  : block clock
//   reset_n       : asynchronous active-low reset
//   ctl           : control bundle (slave side)
//   ad9866_rst_n  : codec reset
//   ad9866_sclk   : SPI clock, idles low, half-period CLKDIV cycles
//   ad9866_sdio   : SPI data, MSB first, changes on sclk falling edge
//   ad9866_sen_n  : SPI enable, active low
module ad9866_spi_ctrl
    import hl_ad9866_pkg::*;
#(
    parameter int CLKDIV = 8,
    parameter int RSTCYC = 256,
    parameter int NINIT  = 8
) (
    input  logic             ad9866spiclk,
    input  logic             reset_n,
    ad9866_spi_ctrl_if.slave ctl,
    output logic             ad9866_rst_n,
    output logic             ad9866_sclk,
    output logic             ad9866_sdio,
    output logic             ad9866_sen_n
);

    // One counter serves the reset hold, the gap and the SCLK half-period.
    localparam int              CW        = $clog2(RSTCYC + 2 * CLKDIV + 1);
    localparam logic [CW-1:0]   RST_LAST  = CW'(RSTCYC - 1);
    localparam logic [CW-1:0]   GAP_LAST  = CW'(2 * CLKDIV - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKDIV - 1);
    localparam logic [4:0]      IDX_LAST  = 5'(NINIT - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [4:0]           idx_q, idx_d;
    logic                 init_run_q, init_run_d;
    logic                 all_issued_q, all_issued_d;
    logic                 init_done_q, init_done_d;
    logic                 rst_n_q, rst_n_d;
    logic                 sclk_q, sclk_d;
    logic                 sdio_q, sdio_d;
    logic                 sen_n_q, sen_n_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;

    logic                 load;
    logic [FRAME_W-1:0]   load_frame;
    logic [ENTRY_W-1:0]   rom_entry;

    ad9866_init_rom #(
        .NINIT (NINIT)
    ) u_rom (
        .idx_i   (idx_q),
        .entry_o (rom_entry)
    );

    always_ff @(posedge ad9866spiclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RSTHOLD;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            init_run_q   <= 1'b1;
            all_issued_q <= 1'b0;
            init_done_q  <= 1'b0;
            rst_n_q      <= 1'b0;
            sclk_q       <= 1'b0;
            sdio_q       <= 1'b0;
            sen_n_q      <= 1'b1;
            ack_q        <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            init_run_q   <= init_run_d;
            all_issued_q <= all_issued_d;
            init_done_q  <= init_done_d;
            rst_n_q      <= rst_n_d;
            sclk_q       <= sclk_d;
            sdio_q       <= sdio_d;
            sen_n_q      <= sen_n_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        init_run_d   = init_run_q;
        all_issued_d = all_issued_q;
        init_done_d  = init_done_q;
        rst_n_d      = rst_n_q;
        sclk_d       = sclk_q;
        sdio_d       = sdio_q;
        sen_n_d      = sen_n_q;
        ack_d        = 1'b0;
        load         = 1'b0;
        load_frame   = '0;

        case (state_q)
            ST_RSTHOLD: begin
                if (cnt_q == RST_LAST) begin
                    rst_n_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (init_run_q && !all_issued_q) begin
                        load       = 1'b1;
                        load_frame = make_frame(rom_entry[ENTRY_W-1 -: FRAME_ADDR_W],
                                                rom_entry[FRAME_DATA_W-1:0]);
                        // Index saturates at the last entry; a separate flag
                        // records that the last entry has gone out.
                        if (idx_q == IDX_LAST) begin
                            all_issued_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        if (init_run_q) begin
                            init_done_d = 1'b1;
                            init_run_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_FRAME: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            // Last falling edge closes the frame.
                            sen_n_d = 1'b1;
                            sdio_d  = 1'b0;
                            state_d = ST_GAP;
                        end else begin
                            sdio_d  = shift_q[FRAME_W-1];
                            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                            bit_d   = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (ctl.reinit) begin
                    init_done_d  = 1'b0;
                    init_run_d   = 1'b1;
                    idx_d        = '0;
                    all_issued_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_GAP;
                end else if (ctl.wr_req && init_done_q) begin
                    ack_d      = 1'b1;
                    load       = 1'b1;
                    load_frame = make_frame(ctl.wr_addr, ctl.wr_data);
                end
            end

            default: begin
                state_d = ST_RSTHOLD;
            end
        endcase

        // Frame start: MSB presented with sen_n falling; the remaining bits
        // wait in the shifter for successive SCLK falling edges.
        if (load) begin
            state_d = ST_FRAME;
            cnt_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            sen_n_d = 1'b0;
            sdio_d  = load_frame[FRAME_W-1];
            shift_d = {load_frame[FRAME_W-2:0], 1'b0};
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign ctl.wr_ack    = ack_q;
    assign ctl.busy      = busy_q;
    assign ctl.init_done = init_done_q;
    assign ad9866_rst_n  = rst_n_q;
    assign ad9866_sclk   = sclk_q;
    assign ad9866_sdio   = sdio_q;
    assign ad9866_sen_n  = sen_n_q;

endmodule

// File: tb/tb_ad9866_spi_ctrl.sv
module tb_ad9866_spi_ctrl;

    localparam int CLKDIV    = 2;
    localparam int RSTCYC    = 16;
    localparam int NINIT     = 4;
    localparam int FRAME_CYC = 32 * CLKDIV;
    localparam int GAP_CYC   = 2 * CLKDIV;
    localparam int BOOT_DONE = RSTCYC + GAP_CYC + NINIT * (FRAME_CYC + GAP_CYC);
    localparam int TIMEOUT   = 2000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic codec_rst_n, sclk, sdio, sen_n;

    ad9866_spi_ctrl_if ctl ();

    ad9866_spi_ctrl #(
        .CLKDIV (CLKDIV),
        .RSTCYC (RSTCYC),
        .NINIT  (NINIT)
    ) dut (
        .ad9866spiclk (clk),
        .reset_n      (reset_n),
        .ctl          (ctl),
        .ad9866_rst_n (codec_rst_n),
        .ad9866_sclk  (sclk),
        .ad9866_sdio  (sdio),
        .ad9866_sen_n (sen_n)
    );

    always #5 clk = ~clk;

    // Expected init frames {0, 00, addr, data} for the first four entries.
    logic [15:0] init_frames [NINIT] = '{16'h0120, 16'h0436, 16'h0540, 16'h064B};

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [15:0] exp_q [$];
    int frames_seen = 0;
    logic [15:0] last_word = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SPI frame decoder: samples pins on the falling clock edge.
    initial begin : monitor
        logic        in_frame, rise_ok, stable_ok, cur_bit;
        logic        prev_sen_n, prev_sclk, prev_sdio;
        logic [15:0] word, exp_word;
        int          t0, rises;
        in_frame = 0; rise_ok = 1; stable_ok = 1; cur_bit = 0;
        prev_sen_n = 1; prev_sclk = 0; prev_sdio = 0;
        word = '0; exp_word = '0; t0 = 0; rises = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_frame = 0;
            end else if (prev_sen_n && !sen_n) begin
                in_frame = 1; t0 = cyc; rises = 0; word = '0;
                rise_ok = 1; stable_ok = 1;
            end else if (in_frame && sen_n) begin
                in_frame = 0;
                check("frame_expected", 32'(exp_q.size() > 0), 32'(1));
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
                check("frame_word", 32'(word), 32'(exp_word));
                check("frame_len", 32'(cyc - t0), 32'(FRAME_CYC));
                check("frame_rises", 32'(rises), 32'(16));
                check("rise_timing", 32'(rise_ok), 32'(1));
                check("sdio_stable", 32'(stable_ok), 32'(1));
                check("sclk_low_at_end", 32'(sclk), 32'(0));
                frames_seen++;
                last_word = word;
                $display("[%0t] frame %0d: word=%h expected=%h", $time, frames_seen, word, exp_word);
            end else if (in_frame) begin
                if (!prev_sclk && sclk) begin
                    if (sdio !== prev_sdio) stable_ok = 0;
                    if (cyc - t0 != (2 * rises + 1) * CLKDIV) rise_ok = 0;
                    word = {word[14:0], sdio};
                    cur_bit = sdio;
                    rises++;
                end else if (sclk && sdio !== cur_bit) begin
                    stable_ok = 0;
                end
            end
            prev_sen_n = sen_n; prev_sclk = sclk; prev_sdio = sdio;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Release reset and follow the boot sequence; optionally raise a write
    // request at cycle 30 (during init).
    task automatic boot(input bit pend);
        int t_rst, t_sen, t_done, t_ack, t_idle, f0, f_done;
        bit ack_early;
        logic [4:0] a;
        logic [7:0] d;
        t_rst = -1; t_sen = -1; t_done = -1; t_ack = -1; t_idle = -1; f_done = 0;
        ack_early = 0;
        a = 5'($urandom);
        d = 8'($urandom);
        for (int i = 0; i < NINIT; i++) exp_q.push_back(init_frames[i]);
        if (pend) exp_q.push_back({3'b000, a, d});
        f0 = frames_seen;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (t_rst < 0 && codec_rst_n) t_rst = cyc;
            if (t_sen < 0 && !sen_n) t_sen = cyc;
            if (t_done < 0 && ctl.init_done) begin
                t_done = cyc;
                f_done = frames_seen - f0;
            end
            if (ctl.wr_ack) begin
                if (t_done < 0) ack_early = 1;
                if (t_ack < 0) t_ack = cyc;
                ctl.wr_req = 1'b0;
            end
            if (pend && cyc == 30) begin
                ctl.wr_addr = a; ctl.wr_data = d; ctl.wr_req = 1'b1;
            end
            if (t_done >= 0 && (!pend || t_ack >= 0) && !ctl.busy) begin
                t_idle = cyc;
                break;
            end
        end
        $display("[%0t] boot: rst_n@%0d sen_n@%0d init_done@%0d pend=%0d ack@%0d", $time, t_rst, t_sen, t_done, pend, t_ack);
        check("boot_finished", 32'(t_idle >= 0), 32'(1));
        check("rst_n_rise", 32'(t_rst), 32'(RSTCYC));
        check("first_sen_fall", 32'(t_sen), 32'(RSTCYC + GAP_CYC));
        check("init_done_time", 32'(t_done), 32'(BOOT_DONE));
        check("init_frame_count", 32'(f_done), 32'(NINIT));
        if (pend) begin
            check("pending_ack_time", 32'(t_ack), 32'(BOOT_DONE + 1));
            check("ack_before_done", 32'(ack_early), 32'(0));
            check("pending_idle_lat", 32'(t_idle - t_ack), 32'(FRAME_CYC + GAP_CYC));
        end
        check("boot_queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    // One runtime write; optional reinit pulse reinit_after cycles past wr_ack.
    task automatic do_write(input logic [4:0] a, input logic [7:0] d, input int reinit_after,
                            output int lat_ack, output int lat_idle);
        int t_req, t_ack, t_idle;
        t_ack = -1; t_idle = -1;
        @(negedge clk);
        ctl.wr_addr = a; ctl.wr_data = d; ctl.wr_req = 1'b1;
        t_req = cyc;
        exp_q.push_back({3'b000, a, d});
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (ctl.reinit) ctl.reinit = 1'b0;
            if (t_ack < 0 && ctl.wr_ack) begin
                t_ack = cyc;
                ctl.wr_req = 1'b0;
            end else if (t_ack >= 0 && reinit_after >= 0 && cyc == t_ack + reinit_after) begin
                ctl.reinit = 1'b1;
            end
            if (t_ack >= 0 && !ctl.busy) begin
                t_idle = cyc;
                break;
            end
        end
        ctl.wr_req = 1'b0;
        ctl.reinit = 1'b0;
        check("write_finished", 32'(t_idle >= 0), 32'(1));
        lat_ack = t_ack - t_req;
        lat_idle = t_idle - t_ack;
        $display("[%0t] write addr=%h data=%h ack_lat=%0d idle_lat=%0d", $time, a, d, lat_ack, lat_idle);
    endtask

    initial begin : stim
        int la, li, t0, t_ack, f0;
        bit rst_low_seen;
        logic [4:0] a;
        logic [7:0] d;
        ctl.reinit = 1'b0; ctl.wr_req = 1'b0; ctl.wr_addr = '0; ctl.wr_data = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_codec_rst_n", 32'(codec_rst_n), 32'(0));
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_sdio", 32'(sdio), 32'(0));
        check("rst_sen_n", 32'(sen_n), 32'(1));
        check("rst_wr_ack", 32'(ctl.wr_ack), 32'(0));
        check("rst_busy", 32'(ctl.busy), 32'(1));
        check("rst_init_done", 32'(ctl.init_done), 32'(0));

        // Boot with a write requested during init
        boot(1'b1);

        // Directed write 09/A5
        do_write(5'h09, 8'hA5, -1, la, li);
        check("dir_ack_lat", 32'(la), 32'(1));
        check("dir_idle_lat", 32'(li), 32'(FRAME_CYC + GAP_CYC));
        check("dir_word", 32'(last_word), 32'(16'h09A5));

        // Random writes
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            a = 5'($urandom);
            d = 8'($urandom);
            do_write(a, d, -1, la, li);
            check("rnd_ack_lat", 32'(la), 32'(1));
            check("rnd_idle_lat", 32'(li), 32'(FRAME_CYC + GAP_CYC));
        end

        // reinit and wr_req in the same IDLE cycle
        a = 5'($urandom);
        d = 8'($urandom);
        for (int i = 0; i < NINIT; i++) exp_q.push_back(init_frames[i]);
        exp_q.push_back({3'b000, a, d});
        f0 = frames_seen;
        rst_low_seen = 0;
        t_ack = -1;
        @(negedge clk);
        ctl.reinit = 1'b1; ctl.wr_req = 1'b1; ctl.wr_addr = a; ctl.wr_data = d;
        t0 = cyc;
        @(negedge clk);
        ctl.reinit = 1'b0;
        check("reinit_clears_done", 32'(ctl.init_done), 32'(0));
        check("reinit_no_ack", 32'(ctl.wr_ack), 32'(0));
        for (int i = 0; i < TIMEOUT; i++) begin
            if (!codec_rst_n) rst_low_seen = 1;
            if (t_ack < 0 && ctl.wr_ack) begin
                t_ack = cyc;
                ctl.wr_req = 1'b0;
            end
            if (t_ack >= 0 && !ctl.busy) break;
            @(negedge clk);
        end
        ctl.wr_req = 1'b0;
        $display("[%0t] reinit+write: ack@%0d frames=%0d", $time, t_ack, frames_seen - f0);
        check("reinit_ack_time", 32'(t_ack), 32'(t0 + 1 + GAP_CYC + NINIT * (FRAME_CYC + GAP_CYC) + 1));
        check("reinit_rst_n_high", 32'(rst_low_seen), 32'(0));
        check("reinit_frames", 32'(frames_seen - f0), 32'(NINIT + 1));
        check("reinit_done", 32'(ctl.init_done), 32'(1));

        // reinit while busy is ignored
        f0 = frames_seen;
        do_write(5'($urandom), 8'($urandom), 5, la, li);
        check("busy_reinit_idle_lat", 32'(li), 32'(FRAME_CYC + GAP_CYC));
        repeat (10) @(negedge clk);
        check("busy_reinit_done", 32'(ctl.init_done), 32'(1));
        check("busy_reinit_frames", 32'(frames_seen - f0), 32'(1));
        check("busy_reinit_queue", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of a frame (bit 7)
        @(negedge clk);
        ctl.wr_addr = 5'($urandom); ctl.wr_data = 8'($urandom); ctl.wr_req = 1'b1;
        t_ack = -1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (ctl.wr_ack) begin
                t_ack = cyc;
                break;
            end
        end
        ctl.wr_req = 1'b0;
        check("midreset_ack_seen", 32'(t_ack >= 0), 32'(1));
        for (int i = 0; i < TIMEOUT && cyc < t_ack + 15 * CLKDIV; i++) @(negedge clk);
        check("midreset_sclk_high_bit7", 32'(sclk), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        $display("[%0t] reset asserted mid-frame", $time);
        check("midreset_sen_n", 32'(sen_n), 32'(1));
        check("midreset_sclk", 32'(sclk), 32'(0));
        check("midreset_codec_rst_n", 32'(codec_rst_n), 32'(0));
        check("midreset_busy", 32'(ctl.busy), 32'(1));
        check("midreset_init_done", 32'(ctl.init_done), 32'(0));
        exp_q.delete();
        repeat (3) @(negedge clk);
        boot(1'b0);

        repeat (10) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
